// File: rtl/arm_core_pkg.sv
// Shared constants for the Thumb-2 stage-one front end: condition codes, APSR bit
// positions, IT opcode byte and the 32-bit instruction prefix patterns.
package arm_core_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int unsigned N_BIT = 4;
  localparam int unsigned Z_BIT = 3;
  localparam int unsigned C_BIT = 2;
  localparam int unsigned V_BIT = 1;
  localparam int unsigned Q_BIT = 0;

  localparam logic [7:0] IT_OPCODE = 8'hBF;

  localparam logic [4:0] PFX_32_A = 5'b11101;
  localparam logic [4:0] PFX_32_B = 5'b11110;
  localparam logic [4:0] PFX_32_C = 5'b11111;

  function automatic logic is_32b_first(input logic [15:0] hw);
    return (hw[15:11] == PFX_32_A) || (hw[15:11] == PFX_32_B) || (hw[15:11] == PFX_32_C);
  endfunction

endpackage

// File: rtl/arm_it_cond_eval.sv
// Combinational evaluator of a 4-bit ARM condition code against the APSR flags.
module arm_it_cond_eval
  import arm_core_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [4:0] i_apsr,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v, w_unused_q;

  assign w_n        = i_apsr[N_BIT];
  assign w_z        = i_apsr[Z_BIT];
  assign w_c        = i_apsr[C_BIT];
  assign w_v        = i_apsr[V_BIT];
  assign w_unused_q = i_apsr[Q_BIT];

  always_comb begin
    o_pass = 1'b1;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !(w_c && !w_z);
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = !(!w_z && (w_n == w_v));
      default: o_pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_core_stage1.sv
// Thumb-2 fetch/decode front end: halfword assembly, APSR flags and, when ARM_CORE_IT_EN
// is defined, IT-block tracking with hint conversion of instructions whose condition fails.
module arm_core_stage1
  import arm_core_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_inst_hw,
  input  logic [4:0]  i_apsr_we,
  input  logic [4:0]  i_apsr_wdata,
  output logic [31:0] o_inst,
  output logic        o_inst_valid,
  output logic        o_hint_or_exc,
  output logic [3:0]  o_cur_cond,
  output logic [7:0]  o_it_state,
  output logic        o_in_it_blk,
  output logic [4:0]  o_apsr
);

  logic        r_pending;
  logic [15:0] r_hw1;
  logic [31:0] r_inst;
  logic        r_valid;
  logic [4:0]  r_apsr;

  // inst is only rewritten when an instruction completes, so it holds while a half is pending
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pending <= 1'b0;
      r_hw1     <= 16'h0000;
      r_inst    <= 32'h0000_0000;
      r_valid   <= 1'b0;
    end else if (r_pending) begin
      r_inst    <= {r_hw1, i_inst_hw};
      r_valid   <= 1'b1;
      r_pending <= 1'b0;
    end else if (is_32b_first(i_inst_hw)) begin
      r_hw1     <= i_inst_hw;
      r_pending <= 1'b1;
      r_valid   <= 1'b0;
    end else begin
      r_inst    <= {i_inst_hw, 16'h0000};
      r_valid   <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_apsr <= 5'b00000;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (i_apsr_we[i]) r_apsr[i] <= i_apsr_wdata[i];
      end
    end
  end

  assign o_inst       = r_inst;
  assign o_inst_valid = r_valid;
  assign o_apsr       = r_apsr;

`ifdef ARM_CORE_IT_EN
  logic [7:0] r_it_state;
  logic       w_is_it;
  logic       w_in_it;
  logic       w_pass;

  assign w_in_it = (r_it_state[3:0] != 4'h0);
  // BFx0 has a zero mask and is an ordinary hint, not an IT
  assign w_is_it = r_valid && (r_inst[31:24] == IT_OPCODE) && (r_inst[19:16] != 4'h0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_it_state <= 8'h00;
    end else if (w_is_it) begin
      r_it_state <= r_inst[23:16];
    end else if (r_valid && w_in_it) begin
      if (r_it_state[2:0] == 3'b000) r_it_state      <= 8'h00;
      else                           r_it_state[4:0] <= {r_it_state[3:0], 1'b0};
    end
  end

  arm_it_cond_eval u_cond_eval (
    .i_cond (r_it_state[7:4]),
    .i_apsr (r_apsr),
    .o_pass (w_pass)
  );

  assign o_it_state    = r_it_state;
  assign o_cur_cond    = r_it_state[7:4];
  assign o_in_it_blk   = w_in_it;
  assign o_hint_or_exc = r_valid && w_in_it && !w_is_it && !w_pass;
`else
  assign o_it_state    = 8'h00;
  assign o_cur_cond    = 4'h0;
  assign o_in_it_blk   = 1'b0;
  assign o_hint_or_exc = 1'b0;
`endif

endmodule

// File: tb/tb_arm_core_stage1.sv
// Randomised bench for arm_core_stage1 against an instruction-level model, plus directed
// literal checks; adapts expectations to whether ARM_CORE_IT_EN is defined.
module tb_arm_core_stage1;

`ifdef ARM_CORE_IT_EN
  localparam bit IT_EN = 1'b1;
`else
  localparam bit IT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst_hw;
  logic [4:0]  apsr_we, apsr_wdata;
  logic [31:0] inst;
  logic        inst_valid, hint_or_exc, in_it_blk;
  logic [3:0]  cur_cond;
  logic [7:0]  it_state;
  logic [4:0]  apsr;

  always #5 clk = ~clk;

  arm_core_stage1 dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_inst_hw    (inst_hw),
    .i_apsr_we    (apsr_we),
    .i_apsr_wdata (apsr_wdata),
    .o_inst       (inst),
    .o_inst_valid (inst_valid),
    .o_hint_or_exc(hint_or_exc),
    .o_cur_cond   (cur_cond),
    .o_it_state   (it_state),
    .o_in_it_blk  (in_it_blk),
    .o_apsr       (apsr)
  );

  int checks = 0;
  int errors = 0;

  // Model: fetched instruction, flags, ITSTATE, and the list of conditions still owed by the
  // current IT block (empty means outside any block).
  logic        m_pending;
  logic [15:0] m_hw1;
  logic [31:0] m_inst;
  logic        m_valid;
  logic [4:0]  m_apsr;
  logic [7:0]  m_it;
  logic [3:0]  m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_pass(input logic [3:0] c, input logic [4:0] f);
    logic n, z, cf, v, base;
    n = f[4]; z = f[3]; cf = f[2]; v = f[1];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic m_is_it();
    return IT_EN && m_valid && (m_inst[31:24] == 8'hBF) && (m_inst[19:16] != 4'h0);
  endfunction

  task automatic model_reset();
    m_pending = 1'b0; m_hw1 = 16'h0; m_inst = 32'h0; m_valid = 1'b0;
    m_apsr = 5'h0; m_it = 8'h0; m_q.delete();
  endtask

  task automatic compare_all();
    logic       ein, ehint;
    logic [3:0] ecur;
    ein   = (m_q.size() > 0);
    ecur  = ein ? m_q[0] : 4'h0;
    ehint = ein && m_valid && !m_is_it() && !cond_pass(ecur, m_apsr);
    chk("inst", inst, m_inst);
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("apsr", 32'(apsr), 32'(m_apsr));
    chk("it_state", 32'(it_state), 32'(m_it));
    chk("in_it_blk", 32'(in_it_blk), 32'(ein));
    chk("cur_cond", 32'(cur_cond), 32'(ecur));
    chk("hint_or_exc", 32'(hint_or_exc), 32'(ehint));
  endtask

  // Predicts the effect of the next rising edge given the inputs now being driven.
  task automatic model_step(input logic [15:0] hw, input logic [4:0] we, input logic [4:0] wd);
    logic [3:0] fc, mk;
    int len;
    if (m_is_it()) begin
      fc = m_inst[23:20]; mk = m_inst[19:16];
      m_it = m_inst[23:16];
      len = mk[0] ? 4 : mk[1] ? 3 : mk[2] ? 2 : 1;
      m_q.delete();
      m_q.push_back(fc);
      for (int j = 1; j < len; j++) m_q.push_back({fc[3:1], mk[4-j]});
    end else if (m_valid && m_q.size() > 0) begin
      void'(m_q.pop_front());
      if (m_it[2:0] == 3'b000) m_it = 8'h00;
      else                     m_it = {m_it[7:5], m_it[3:0], 1'b0};
    end
    m_apsr = (m_apsr & ~we) | (wd & we);
    if (m_pending) begin
      m_inst = {m_hw1, hw}; m_valid = 1'b1; m_pending = 1'b0;
    end else if (hw[15:13] == 3'b111 && hw[12:11] != 2'b00) begin
      m_hw1 = hw; m_pending = 1'b1; m_valid = 1'b0;
    end else begin
      m_inst = {hw, 16'h0000}; m_valid = 1'b1;
    end
  endtask

  task automatic step(input logic [15:0] hw, input logic [4:0] we, input logic [4:0] wd);
    @(negedge clk);
    compare_all();
    inst_hw = hw; apsr_we = we; apsr_wdata = wd;
    model_step(hw, we, wd);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0; inst_hw = 16'h0; apsr_we = 5'h0; apsr_wdata = 5'h0;
    model_reset();
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_it_state", 32'(it_state), 32'h0);
    chk("rst_apsr", 32'(apsr), 32'h0);
    chk("rst_hint", 32'(hint_or_exc), 32'h0);
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    model_step(inst_hw, apsr_we, apsr_wdata);
  endtask

  initial begin
    logic [15:0] hw;
    logic [4:0]  we, wd;
    int r;
    rst = 1'b0; inst_hw = 16'h0; apsr_we = 5'h0; apsr_wdata = 5'h0;
    model_reset();
    do_reset();

    step(16'h2001, 5'h0, 5'h0); settle();
    chk("first_inst", inst, 32'h2001_0000);
    chk("first_valid", 32'(inst_valid), 32'h1);
    chk("first_hint", 32'(hint_or_exc), 32'h0);

    step(16'hF000, 5'h0, 5'h0); settle();
    chk("w32_first_valid", 32'(inst_valid), 32'h0);
    step(16'h8000, 5'h0, 5'h0); settle();
    chk("w32_inst", inst, 32'hF000_8000);
    chk("w32_valid", 32'(inst_valid), 32'h1);
    step(16'h2002, 5'h0, 5'h0); settle();
    chk("after_w32_inst", inst, 32'h2002_0000);

    // IT EQ with Z=0, then with Z=1
    step(16'hBF08, 5'h0, 5'h0);
    step(16'h2001, 5'h0, 5'h0); settle();
    chk("iteq_it_state", 32'(it_state), IT_EN ? 32'h08 : 32'h0);
    chk("iteq_in_blk", 32'(in_it_blk), 32'(IT_EN));
    chk("iteq_hint", 32'(hint_or_exc), 32'(IT_EN));
    step(16'h2003, 5'h0, 5'h0); settle();
    chk("iteq_end_state", 32'(it_state), 32'h0);
    step(16'h2000, 5'b01000, 5'b01000);
    step(16'hBF08, 5'h0, 5'h0);
    step(16'h2001, 5'h0, 5'h0); settle();
    chk("iteq_z1_hint", 32'(hint_or_exc), 32'h0);
    step(16'h2000, 5'b01000, 5'b00000);

    // ITTE NE
    step(16'hBF1A, 5'h0, 5'h0);
    step(16'h2001, 5'h0, 5'h0); settle();
    chk("itte_st0", 32'(it_state), IT_EN ? 32'h1A : 32'h0);
    chk("itte_cc0", 32'(cur_cond), IT_EN ? 32'h1 : 32'h0);
    chk("itte_h0", 32'(hint_or_exc), 32'h0);
    step(16'h2002, 5'h0, 5'h0); settle();
    chk("itte_st1", 32'(it_state), IT_EN ? 32'h14 : 32'h0);
    chk("itte_h1", 32'(hint_or_exc), 32'h0);
    step(16'h2003, 5'h0, 5'h0); settle();
    chk("itte_st2", 32'(it_state), IT_EN ? 32'h08 : 32'h0);
    chk("itte_cc2", 32'(cur_cond), 32'h0);
    chk("itte_h2", 32'(hint_or_exc), 32'(IT_EN));
    step(16'h2004, 5'h0, 5'h0); settle();
    chk("itte_st3", 32'(it_state), 32'h0);

    // ITT GE with N=1,V=0 written alongside the IT
    step(16'hBFA4, 5'b10010, 5'b10000);
    step(16'h2001, 5'h0, 5'h0); settle();
    chk("ge_flip_hint", 32'(hint_or_exc), 32'(IT_EN));
    step(16'h2002, 5'b10010, 5'b00000); #1;
    chk("ge_prewrite_hint", 32'(hint_or_exc), 32'(IT_EN));
    settle();
    chk("ge_postwrite_apsr", 32'(apsr), 32'h0);
    chk("ge_postwrite_hint", 32'(hint_or_exc), 32'h0);
    step(16'h2000, 5'b10010, 5'b10000);
    step(16'h2005, 5'h0, 5'h0); settle();
    chk("outside_blk_hint", 32'(hint_or_exc), 32'h0);
    chk("outside_blk_in", 32'(in_it_blk), 32'h0);
    step(16'h2000, 5'b10010, 5'b00000);

    // AL block and mask-zero hint
    step(16'hBFE8, 5'h0, 5'h0);
    step(16'h2001, 5'h0, 5'h0); settle();
    chk("al_cur_cond", 32'(cur_cond), IT_EN ? 32'hE : 32'h0);
    chk("al_hint", 32'(hint_or_exc), 32'h0);
    step(16'hBF30, 5'h0, 5'h0);
    step(16'h2002, 5'h0, 5'h0); settle();
    chk("bf30_it_state", 32'(it_state), 32'h0);

    // Reset while a first half is pending discards it
    step(16'hF123, 5'h0, 5'h0);
    do_reset();
    step(16'h2001, 5'h0, 5'h0); settle();
    chk("rst_pending_inst", inst, 32'h2001_0000);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      hw = 16'($urandom);
      if (r < 25)      hw[15:11] = 5'($urandom_range(29, 31));
      else if (r < 45) hw[15:8] = 8'hBF;
      else if (hw[15:13] == 3'b111) hw[15] = 1'b0;
      we = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
      wd = 5'($urandom);
      step(hw, we, wd);
      if (i == 1500) begin
        step(16'hF800, 5'h0, 5'h0);
        do_reset();
      end
    end

    @(negedge clk);
    compare_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
